// File: rtl/a23_mem_pkg.sv
// Shared definitions for the a23 memory-map DMA engine: region codes,
// operation modes, FSM states and the region write-permission rule.
package a23_mem_pkg;

  localparam logic [7:0] REG_CODE  = 8'h00;
  localparam logic [7:0] REG_G     = 8'h01;
  localparam logic [7:0] REG_E     = 8'h02;
  localparam logic [7:0] REG_OUT   = 8'h03;
  localparam logic [7:0] REG_STACK = 8'h04;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_FILL = 2'b01,
    MODE_SUM  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Garbler/Evaluator inputs are read-only; unmapped regions drop writes.
  function automatic logic region_writable(input logic [7:0] region);
    case (region)
      REG_CODE, REG_OUT, REG_STACK: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/a23_mem_addr_step.sv
// Word-address stepper: advances source and destination by one word inside
// their region (region byte held, offset wraps) and vets the destination region.
module a23_mem_addr_step
  import a23_mem_pkg::*;
(
  input  logic [31:0] i_src,
  input  logic [31:0] i_dst,
  output logic [31:0] o_src_next,
  output logic [31:0] o_dst_next,
  output logic        o_dst_writable
);

  logic unused_low_bits;
  assign unused_low_bits = ^{i_src[1:0], i_dst[1:0]};

  assign o_src_next     = {i_src[31:24], i_src[23:2] + 22'd1, 2'b00};
  assign o_dst_next     = {i_dst[31:24], i_dst[23:2] + 22'd1, 2'b00};
  assign o_dst_writable = region_writable(i_dst[31:24]);

endmodule

// File: rtl/a23_mem_dma.sv
// a23 memory-map DMA engine: copy, fill and checksum over word blocks,
// driving the core's single-port bus only while busy.
module a23_mem_dma
  import a23_mem_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [31:0]      i_fill_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [31:0]      o_sum,
  output logic [31:0]      o_m_address,
  output logic [31:0]      o_m_write,
  output logic             o_m_write_en,
  output logic [3:0]       o_m_byte_enable,
  input  logic [31:0]      i_m_read
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      sum_q, sum_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [31:0] src_next_s, dst_next_s, step_dst_s;
  logic        dst_writable_s, last_word_s;
  logic        unused_src_low;

  assign unused_src_low = ^i_src_addr[1:0];

  // While idle the stepper looks at the requested destination so its region can be vetted.
  assign step_dst_s  = (state_q == ST_IDLE) ? i_dst_addr : dst_q;
  assign last_word_s = (count_q == LEN_W'(1));

  a23_mem_addr_step u_step (
    .i_src          (src_q),
    .i_dst          (step_dst_s),
    .o_src_next     (src_next_s),
    .o_dst_next     (dst_next_s),
    .o_dst_writable (dst_writable_s)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    sum_d   = sum_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mode_d  = mode_e'(i_mode);
          src_d   = {i_src_addr[31:2], 2'b00};
          dst_d   = {i_dst_addr[31:2], 2'b00};
          count_d = i_len;
          data_d  = i_fill_data;
          sum_d   = 32'h0;
          err_d   = 1'b0;
          if (i_mode == MODE_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if ((i_mode != MODE_SUM) && !dst_writable_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (i_len == '0) begin
            state_d = ST_DONE;
          end else if (i_mode == MODE_FILL) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mode_q == MODE_SUM) begin
          sum_d   = sum_q + i_m_read;
          src_d   = src_next_s;
          count_d = count_q - LEN_W'(1);
          state_d = last_word_s ? ST_DONE : ST_RD;
        end else begin
          data_d  = i_m_read;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        dst_d   = dst_next_s;
        count_d = count_q - LEN_W'(1);
        if (mode_q == MODE_COPY) begin
          src_d = src_next_s;
        end else begin
          src_d = src_q;
        end
        if (last_word_s) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      data_q  <= 32'h0;
      sum_q   <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Bus drive is decoded from state only, so a reset releases the bus at once.
  always_comb begin
    o_m_address     = 32'h0;
    o_m_write       = 32'h0;
    o_m_write_en    = 1'b0;
    o_m_byte_enable = 4'h0;
    case (state_q)
      ST_RD: o_m_address = src_q;
      ST_WR: begin
        o_m_address     = dst_q;
        o_m_write       = data_q;
        o_m_write_en    = 1'b1;
        o_m_byte_enable = 4'hF;
      end
      default: o_m_address = 32'h0;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);
  assign o_err  = err_q;
  assign o_sum  = sum_q;

endmodule

// File: tb/tb_a23_mem_dma.sv
// Bench for a23_mem_dma: a behavioural memory/transfer model predicts every
// bus cycle, the final memory image, o_sum and o_err for directed and random ops.
module tb_a23_mem_dma;
  localparam int LEN_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [31:0]      src, dst, fill;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [31:0]      sum, m_addr, m_wdata, m_read;
  logic             m_we;
  logic [3:0]       m_be;

  a23_mem_dma #(.LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len), .i_fill_data(fill),
    .o_busy(busy), .o_done(done), .o_err(err), .o_sum(sum),
    .o_m_address(m_addr), .o_m_write(m_wdata), .o_m_write_en(m_we),
    .o_m_byte_enable(m_be), .i_m_read(m_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory decodes region addr[26:24] and word index addr[11:2].
  logic [31:0] mem     [0:7][0:1023];
  logic [31:0] ref_mem [0:7][0:1023];
  assign m_read = (m_addr[31:24] <= 8'h04) ? mem[m_addr[26:24]][m_addr[11:2]] : 32'h0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        we;
    logic        chk_w;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wr_log[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          done_at;
  logic        m_err;
  logic [31:0] m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic writable(input logic [7:0] r);
    return (r == 8'h00) || (r == 8'h03) || (r == 8'h04);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] base, input int i);
    logic [23:0] off;
    off = {base[23:2], 2'b00} + 24'(i * 4);
    return {base[31:24], off};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (a[31:24] <= 8'h04) return ref_mem[a[26:24]][a[11:2]];
    return 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] v);
    if (writable(a[31:24])) ref_mem[a[26:24]][a[11:2]] = v;
  endtask

  task automatic poke_mem(input logic [31:0] a, input logic [31:0] v);
    mem[a[26:24]][a[11:2]]     = v;
    ref_mem[a[26:24]][a[11:2]] = v;
  endtask

  task automatic push(input logic b, input logic d, input logic we, input logic cw,
                      input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    e.busy = b; e.done = d; e.we = we; e.chk_w = cw;
    e.be = we ? 4'hF : 4'h0; e.addr = a; e.wdata = w;
    exp_q.push_back(e);
  endtask

  // Transfer semantics as a word-by-word walk over the model memory.
  task automatic model_op(input logic [1:0] md, input logic [31:0] s, input logic [31:0] d,
                          input int n, input logic [31:0] f);
    logic [31:0] sa, da, v;
    m_err = 1'b0;
    m_sum = 32'h0;
    if (md == 2'b11 || (md != 2'b10 && !writable(d[31:24]))) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        sa = word_addr(s, i);
        da = word_addr(d, i);
        if (md == 2'b00) begin
          v = ref_rd(sa);
          push(1'b1, 1'b0, 1'b0, 1'b0, sa, 32'h0);
          push(1'b1, 1'b0, 1'b1, 1'b1, da, v);
          ref_wr(da, v);
        end else if (md == 2'b01) begin
          push(1'b1, 1'b0, 1'b1, 1'b1, da, f);
          ref_wr(da, f);
        end else begin
          m_sum = m_sum + ref_rd(sa);
          push(1'b1, 1'b0, 1'b0, 1'b0, sa, 32'h0);
        end
      end
    end
    push(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic cmp_cycle();
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    if (exp_q.size() == 0 && !e.busy) e.chk_w = 1'b1;
    checks++;
    if (busy !== e.busy || done !== e.done || m_we !== e.we || m_be !== e.be ||
        m_addr !== e.addr || (e.chk_w && m_wdata !== e.wdata)) begin
      failures++;
      $display("FAIL bus_cycle %0d: got busy=%b done=%b we=%b be=%h addr=%h wdata=%h expected busy=%b done=%b we=%b be=%h addr=%h wdata=%h",
               cyc, busy, done, m_we, m_be, m_addr, m_wdata, e.busy, e.done, e.we, e.be, e.addr, e.wdata);
    end
  endtask

  task automatic commit();
    if (m_we === 1'b1) begin
      wr_log.push_back(m_addr);
      if (writable(m_addr[31:24])) mem[m_addr[26:24]][m_addr[11:2]] = m_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    cmp_cycle();
    if (done === 1'b1) done_at = cyc;
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 1024; i++)
        if (mem[r][i] !== ref_mem[r][i]) begin
          if (bad == 0)
            $display("FAIL %s: word r%0d[%0d] got %h expected %h", name, r, i, mem[r][i], ref_mem[r][i]);
          bad++;
        end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic launch(input logic [1:0] md, input logic [31:0] s, input logic [31:0] d,
                        input int n, input logic [31:0] f);
    start = 1'b1; mode = md; src = s; dst = d; len = LEN_W'(n); fill = f;
    @(posedge clk);
    #1;
    start = 1'b0; mode = 2'($urandom); src = $urandom; dst = $urandom;
    len = LEN_W'($urandom); fill = $urandom;
    wr_log.delete();
    cyc = 0;
    done_at = -1;
    model_op(md, s, d, n, f);
  endtask

  task automatic run_op(input logic [1:0] md, input logic [31:0] s, input logic [31:0] d,
                        input int n, input logic [31:0] f, input bit poke);
    launch(md, s, d, n, f);
    while (exp_q.size() > 0 && cyc < 200) begin
      tick();
      if (poke && cyc == 2) begin
        start = 1'b1; mode = 2'b00; src = 32'h02000000; dst = 32'h00000000; len = LEN_W'(7);
      end else begin
        start = 1'b0;
      end
    end
    if (exp_q.size() > 0) begin
      chk("op_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    tick();
    chk("err", {31'h0, err}, {31'h0, m_err});
    chk("sum", sum, m_sum);
    chk_mem("mem_image");
  endtask

  initial begin
    logic [31:0] rs, rd, t;
    logic [1:0]  rm;
    int          rl;
    rst = 1'b1; start = 1'b0; mode = 2'b00; src = 32'h0; dst = 32'h0; len = '0; fill = 32'h0;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 1024; i++) begin
        t = $urandom;
        mem[r][i] = t;
        ref_mem[r][i] = t;
      end
    @(posedge clk); @(posedge clk); #1;
    chk("rst_outputs", {busy, done, err, m_we, m_be, 22'h0}, 32'h0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Copy 4 Garbler words into Stack words 4..7.
    poke_mem(32'h01000000, 32'h11111111); poke_mem(32'h01000004, 32'h22222222);
    poke_mem(32'h01000008, 32'h33333333); poke_mem(32'h0100000C, 32'h44444444);
    run_op(2'b00, 32'h01000000, 32'h04000010, 4, 32'h0, 1'b0);
    chk("copy_done_at", 32'(done_at), 32'd9);
    chk("copy_w4", mem[4][4], 32'h11111111);
    chk("copy_w7", mem[4][7], 32'h44444444);
    chk("copy_nwr", 32'(wr_log.size()), 32'd4);

    run_op(2'b01, 32'h0, 32'h03000000, 3, 32'hDEADBEEF, 1'b0);
    chk("fill_done_at", 32'(done_at), 32'd4);
    chk("fill_w0", mem[3][0], 32'hDEADBEEF);
    chk("fill_w2", mem[3][2], 32'hDEADBEEF);

    poke_mem(32'h02000000, 32'hFFFFFFFF); poke_mem(32'h02000004, 32'h00000002);
    run_op(2'b10, 32'h02000000, 32'h0, 2, 32'h0, 1'b0);
    chk("sum_wrap", sum, 32'h00000001);
    chk("sum_nwr", 32'(wr_log.size()), 32'd0);
    chk("sum_done_at", 32'(done_at), 32'd3);

    run_op(2'b01, 32'h0, 32'h01000000, 5, 32'h12345678, 1'b0);
    chk("ro_err", {31'h0, err}, 32'd1);
    chk("ro_done_at", 32'(done_at), 32'd1);
    chk("ro_nwr", 32'(wr_log.size()), 32'd0);
    run_op(2'b11, 32'h01000000, 32'h04000000, 3, 32'h0, 1'b0);
    chk("rsvd_err", {31'h0, err}, 32'd1);
    chk("rsvd_done_at", 32'(done_at), 32'd1);
    run_op(2'b00, 32'h01000000, 32'h04000000, 0, 32'h0, 1'b0);
    chk("len0_err", {31'h0, err}, 32'd0);
    chk("len0_done_at", 32'(done_at), 32'd1);

    run_op(2'b01, 32'h0, 32'h04FFFFFC, 2, 32'hA5A5F00D, 1'b0);
    chk("wrap_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("wrap_a0", wr_log[0], 32'h04FFFFFC);
      chk("wrap_a1", wr_log[1], 32'h04000000);
    end

    // Start pulsed while busy must not disturb the fill in flight.
    run_op(2'b01, 32'h0, 32'h00000100, 4, 32'hCAFEF00D, 1'b1);
    chk("poke_done_at", 32'(done_at), 32'd5);

    // Reset during word 2's write cycle of a copy.
    for (int i = 8; i < 12; i++) poke_mem(32'h04000000 + 32'(i * 4), 32'h0);
    launch(2'b00, 32'h01000000, 32'h04000020, 4, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    cyc++;
    cmp_cycle();
    rst = 1'b1;
    #1;
    chk("abort_we", {31'h0, m_we}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    commit();
    exp_q.delete();
    ref_mem[4][10] = 32'h0;
    ref_mem[4][11] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_w0", mem[4][8], 32'h11111111);
    chk("abort_w1", mem[4][9], 32'h22222222);
    chk("abort_w2", mem[4][10], 32'h0);
    chk("abort_err", {31'h0, err}, 32'd0);
    chk_mem("abort_image");
    @(posedge clk); #1;
    run_op(2'b00, 32'h01000004, 32'h00000040, 3, 32'h0, 1'b0);
    chk("restart_done_at", 32'(done_at), 32'd7);

    for (int n = 0; n < 40; n++) begin
      rm = 2'($urandom_range(0, 3));
      rs = {pick_region(), 12'h000, 10'($urandom_range(0, 63)), 2'($urandom)};
      rd = {pick_region(), 12'h000, 10'($urandom_range(0, 63)), 2'($urandom)};
      if (rm == 2'b00 && rs[31:24] == rd[31:24] && rd[23:2] > rs[23:2]) begin
        t = rs; rs = rd; rd = t;
      end
      rl = $urandom_range(0, 8);
      run_op(rm, rs, rd, rl, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] pick_region();
    case ($urandom_range(0, 6))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h03;
      4:       return 8'h04;
      5:       return 8'h05;
      default: return 8'h7F;
    endcase
  endfunction

endmodule

// File: doc/a23_mem_dma.md
Name: a23_mem_dma

Overview:
- Bus initiator for the a23 memory map; drives the same single-port address/write/write-enable/byte-enable/read-data interface the core uses.
- Moves word blocks between regions for the garbled-circuit flow, e.g. Garbler/Evaluator inputs into Stack, or Stack results into Out.
- Three modes: copy, fill and checksum.
- Sits beside the core behind an external bus mux; owns the bus only while o_busy=1.

Parameters:
- LEN_W, 16, width of word-count input; max transfer 2^LEN_W-1 words.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- i_mode  in  2  00 copy, 01 fill, 10 checksum, 11 reserved (treated as error)
- i_src_addr  in  32  source byte address (copy/checksum)
- i_dst_addr  in  32  destination byte address (copy/fill)
- i_len  in  LEN_W  number of 32-bit words
- i_fill_data  in  32  fill pattern
- o_busy  out  1  engine owns bus
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error of last operation
- o_sum  out  32  checksum result
- o_m_address  out  32  bus address
- o_m_write  out  32  bus write data
- o_m_write_en  out  1  bus write strobe
- o_m_byte_enable  out  4  bus byte enables
- i_m_read  in  32  bus read data, combinational from o_m_address same cycle

Behaviour:
- Memory map: region = addr[31:24]. 00 Code (rw), 01 Garbler (ro), 02 Evaluator (ro), 03 Out (rw), 04 Stack (rw). Others unmapped: read 0, writes dropped.
- Reset: all outputs 0; FSM IDLE; src/dst/count/data/sum registers 0. Reset mid-operation aborts immediately: o_m_write_en drops asynchronously, no done pulse, partial writes remain.
- FSM states: IDLE, RD, WR, DONE.
- IDLE: on i_start, latch inputs and set sum=0, err=0, then:
  - mode 11 -> DONE with err=1.
  - copy/fill with dst region not in {00,03,04} -> DONE with err=1, no bus writes.
  - len=0 -> DONE, err=0.
  - otherwise copy/checksum -> RD; fill -> WR.
- RD: o_m_address={src[31:2],2'b00}, write_en=0, byte_enable=0000.
  - Copy: data_reg<=i_m_read, then -> WR.
  - Checksum: sum<=sum+i_m_read mod 2^32; src+=4; count-=1; -> RD, or DONE when count reaches 0.
- WR: o_m_address={dst[31:2],2'b00}, o_m_write=data_reg (copy) or i_fill_data (fill), write_en=1, byte_enable=1111. Then dst+=4, src+=4 (copy), count-=1. Next state: DONE if count=0, else RD (copy) or WR (fill).
- DONE: o_done=1 for exactly one cycle, o_busy=1; -> IDLE.
- o_busy=1 in RD/WR/DONE.
- Throughput: copy 2 cycles/word; fill and checksum 1 cycle/word.
- Latency: start sampled at edge T; first bus cycle T+1; done at T+1+k (k = bus cycles); IDLE at T+2+k.
- Address increment applies to bits [23:2] only. Region byte is held, so 0x04FFFFFC wraps to 0x04000000. addr[1:0] are ignored throughout.
- In IDLE/DONE: o_m_address=0, o_m_write=0, write_en=0, byte_enable=0.
- i_start outside IDLE is ignored; input changes after the start edge are ignored.
- o_sum and o_err hold until the next accepted start.
- Source region is unchecked: reads from unmapped regions yield 0.
- Copy with overlapping ranges proceeds strictly ascending. This is correct for dst<=src; for dst>src the result is unspecified.

Decomposition:
- Shared package a23_mem_pkg holds:
  - region codes REG_CODE=8'h00, REG_G=8'h01, REG_E=8'h02, REG_OUT=8'h03, REG_STACK=8'h04
  - mode encodings MODE_COPY/MODE_FILL/MODE_SUM/MODE_RSVD
  - FSM state encodings
  - function region_writable(region)
- One sub-module: a23_mem_addr_step, combinational: next address with region-preserving wrap, plus writable check.

Test Plan:
- Copy 4 words from 0x01000000 (g_init words 0x11111111..0x44444444) to 0x04000010, len=4 -> 8 bus cycles alternating RD/WR; stack words 4..7 hold the values; done at T+9; err=0.
- Fill 0xDEADBEEF to 0x03000000, len=3 -> 3 consecutive WR cycles with byte_enable=1111; out words 0..2 = 0xDEADBEEF; done at T+4.
- Checksum 0x02000000, len=2, e words 0xFFFFFFFF and 0x00000002 -> o_sum=0x00000001 (wraps); no write_en ever asserted.
- Fill to 0x01000000 len=5, then mode 11, then len=0 copy -> first two: err=1, done at T+1, zero writes; len=0 case: err=0, done at T+1.
- Fill at 0x04FFFFFC len=2 -> writes to 0x04FFFFFC then 0x04000000.
- Reset mid-copy after word 2's WR: write_en drops immediately; words 0..1 written, word 2 not; busy=0; new start accepted.
- Start pulsed during busy -> ignored; outputs unchanged.
